// File: rtl/qsys_serial_pkg.sv
// qsys_serial_pkg
// Shared types and helpers for the Avalon-MM to serial-link bridge.
//   state_t              : bridge transaction states
//   RESP_OKAY/SLVERR/DECERR : Avalon response codes
//   frameWidth()         : request frame length {rw, byteenable, address, data}
//   respWidth()          : response length, {err, data} for reads, {err} for writes
package qsys_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_WAIT_RDY,
    ST_RECV,
    ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int frameWidth(input int addrW, input int dataW);
    return 1 + dataW / 8 + addrW + dataW;
  endfunction

  function automatic int respWidth(input int dataW, input logic isWrite);
    return isWrite ? 1 : 1 + dataW;
  endfunction

endpackage

// File: rtl/qsys_serial_clkgen.sv
// qsys_serial_clkgen
// Divided serial clock generator. While enabled, sclk toggles every CLK_DIV
// input cycles starting from low; when disabled it is held low and the
// divider restarts, so every enabled burst begins with a full low half-period.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : run the divider
//   o_sclk         : registered serial clock
//   o_rise/o_fall  : high in the cycle whose closing edge drives sclk high/low
module qsys_serial_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  // Half-period divider; dropping the enable parks sclk low immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= !r_sclk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qsys_serial_bridge.sv
// qsys_serial_bridge
// Avalon-MM slave that forwards each transaction as a serial frame
// {rw, byteenable, address, data} (MSB first) and collects a status /
// read-back response after the remote raises srdy.
//   csi_MCLK_clk, rsi_MRST_reset_n : clock, asynchronous active-low reset
//   avs_ctrl_*                     : Avalon-MM slave port (waitrequest low only in DONE)
//   sclk, sle, sdo                 : serial clock, frame enable, data out
//   sdi, srdy                      : serial data in, asynchronous remote ready
module qsys_serial_bridge
  import qsys_serial_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                csi_MCLK_clk,
  input  logic                rsi_MRST_reset_n,
  input  logic [ADDR_W-1:0]   avs_ctrl_address,
  input  logic [DATA_W-1:0]   avs_ctrl_writedata,
  input  logic [DATA_W/8-1:0] avs_ctrl_byteenable,
  input  logic                avs_ctrl_write,
  input  logic                avs_ctrl_read,
  output logic [DATA_W-1:0]   avs_ctrl_readdata,
  output logic [1:0]          avs_ctrl_response,
  output logic                avs_ctrl_waitrequest,
  output logic                sclk,
  output logic                sle,
  output logic                sdo,
  input  logic                sdi,
  input  logic                srdy
);

  localparam int FRAME_W = frameWidth(ADDR_W, DATA_W);
  localparam int RX_W    = DATA_W + 1;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next;
  logic [FRAME_W-1:0]  r_shift;
  logic [RX_W-1:0]     r_rx;
  logic [CNT_W-1:0]    r_bitCnt;
  logic [CNT_W-1:0]    w_respLast;
  logic [TO_W-1:0]     r_toCnt;
  logic                r_isWrite;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_sle;
  logic                r_waitreq;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_resp;
  logic [DATA_W-1:0]   w_txData;
  logic                w_sclkEn;
  logic                w_rise;
  logic                w_fall;
  logic                w_err;

  qsys_serial_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .i_clk   (csi_MCLK_clk),
    .i_rst_n (rsi_MRST_reset_n),
    .i_en    (w_sclkEn),
    .o_sclk  (sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_sclkEn   = (r_state == ST_SHIFT) || (r_state == ST_RECV);
  assign w_txData   = avs_ctrl_write ? avs_ctrl_writedata : {DATA_W{1'b0}};
  assign w_respLast = CNT_W'(respWidth(DATA_W, r_isWrite) - 1);
  assign w_err      = r_isWrite ? r_rx[0] : r_rx[DATA_W];

  assign sdo                  = r_shift[FRAME_W-1];
  assign sle                  = r_sle;
  assign avs_ctrl_waitrequest = r_waitreq;
  assign avs_ctrl_readdata    = r_rdata;
  assign avs_ctrl_response    = r_resp;

  // Next-state logic. Bit periods end on sclk falling strobes, so each
  // serial phase lasts a whole number of sclk periods and leaves sclk low.
  // A ready remote wins over a timeout that expires in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (avs_ctrl_write || avs_ctrl_read) w_next = ST_LOAD;
      ST_LOAD:     w_next = ST_SHIFT;
      ST_SHIFT:    if (w_fall && (r_bitCnt == CNT_W'(FRAME_W - 1))) w_next = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (r_sync2) w_next = ST_RECV;
        else if (r_toCnt == TO_W'(TIMEOUT - 1)) w_next = ST_DONE;
      end
      ST_RECV:     if (w_fall && (r_bitCnt == w_respLast)) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) r_state <= ST_IDLE;
    else                   r_state <= w_next;
  end

  // srdy synchroniser plus the registered sle/waitrequest, which are
  // derived from the next state so they line up exactly with SHIFT/DONE.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sle     <= 1'b0;
      r_waitreq <= 1'b1;
    end else begin
      r_sync1   <= srdy;
      r_sync2   <= r_sync1;
      r_sle     <= (w_next == ST_SHIFT);
      r_waitreq <= (w_next != ST_DONE);
    end
  end

  // Timeout counter: equals the number of WAIT_RDY cycles already spent,
  // and is zero everywhere else so each wait starts from a clean count.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) r_toCnt <= '0;
    else if ((r_state == ST_WAIT_RDY) && (w_next == ST_WAIT_RDY)) r_toCnt <= r_toCnt + 1'b1;
    else r_toCnt <= '0;
  end

  // Frame/response datapath. The shift register fills with zeros as it
  // empties, which returns sdo to 0 after the last frame bit. Received bits
  // are taken on the edge that drives sclk high.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_shift   <= '0;
      r_rx      <= '0;
      r_bitCnt  <= '0;
      r_isWrite <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_isWrite <= avs_ctrl_write;
          r_shift   <= {avs_ctrl_write, avs_ctrl_byteenable, avs_ctrl_address, w_txData};
          r_rx      <= '0;
          r_bitCnt  <= '0;
        end
        ST_SHIFT: begin
          if (w_fall) begin
            r_shift  <= {r_shift[FRAME_W-2:0], 1'b0};
            r_bitCnt <= (w_next == ST_SHIFT) ? r_bitCnt + 1'b1 : '0;
          end
        end
        ST_RECV: begin
          if (w_rise) r_rx <= {r_rx[RX_W-2:0], sdi};
          if (w_fall) r_bitCnt <= (w_next == ST_RECV) ? r_bitCnt + 1'b1 : '0;
        end
        default: ;
      endcase
    end
  end

  // Result registers, loaded on entry to DONE and held until the next one.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_rdata <= '0;
      r_resp  <= RESP_OKAY;
    end else if (w_next == ST_DONE) begin
      if (r_state == ST_WAIT_RDY) begin
        r_rdata <= '0;
        r_resp  <= RESP_DECERR;
      end else begin
        r_rdata <= r_isWrite ? {DATA_W{1'b0}} : r_rx[DATA_W-1:0];
        r_resp  <= w_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: doc/qsys_serial_bridge.md
# qsys_serial_bridge

Avalon-MM slave that carries each bus transaction over a 4-wire serial link to a remote register device, as the parametrised successor of the fixed 8-bit-address/32-bit-data serial device. It adds configurable address and data widths, a divided serial clock, transmitted byte enables, a fixed-length status/read-back response and a ready timeout. Errors are reported on the Avalon `response` signal. It sits between the Qsys interconnect and off-chip or far-fabric peripheral registers.

## Interface
- `ADDR_W`, default 8: address bits sent per frame.
- `DATA_W`, default 32: data bits; must be a multiple of 8.
- `CLK_DIV`, default 2: `sclk` half-period in `csi_MCLK_clk` cycles; must be ≥1.
- `TIMEOUT`, default 1023: maximum WAIT_RDY cycles before abort; must be ≥1.
- `csi_MCLK_clk`, in, 1: single clock.
- `rsi_MRST_reset_n`, in, 1: reset, asynchronous, active-low.
- `avs_ctrl_address`, in, ADDR_W: word address.
- `avs_ctrl_writedata`, in, DATA_W: write data.
- `avs_ctrl_byteenable`, in, DATA_W/8: byte enables, forwarded to the link.
- `avs_ctrl_write`, `avs_ctrl_read`, in, 1: commands.
- `avs_ctrl_readdata`, out, DATA_W: read data, valid in the DONE cycle.
- `avs_ctrl_response`, out, 2: 00 OKAY, 10 SLVERR, 11 DECODEERROR (timeout).
- `avs_ctrl_waitrequest`, out, 1: low only in the DONE cycle.
- `sclk`, out, 1: serial clock; low when idle.
- `sle`, out, 1: frame enable; high during SHIFT only.
- `sdo`, out, 1: serial data out, MSB first.
- `sdi`, in, 1: serial data in, sampled on `sclk` rising.
- `srdy`, in, 1: remote ready; asynchronous; passes through a 2-flop synchroniser.

## Operation
- Frame layout: FRAME_W = 1+DATA_W/8+ADDR_W+DATA_W bits, in the order {rw (1 = write), byteenable, address, data}, sent MSB first. Data is zero for reads.
- Response layout: RESP_W = 1+DATA_W bits for reads ({err, data}) and 1 bit for writes ({err}), received MSB first.
- States and transitions:
  - IDLE → LOAD when `write` or `read` is high. Write wins if both are high.
  - LOAD → SHIFT.
  - SHIFT → WAIT_RDY after FRAME_W `sclk` periods.
  - WAIT_RDY → RECV when synchronised `srdy` is 1.
  - WAIT_RDY → DONE with response 11 and readdata 0 when the timeout counter reaches TIMEOUT.
  - RECV → DONE after RESP_W `sclk` periods.
  - DONE → IDLE.
- Command signals are captured in LOAD. The master must hold the command while `waitrequest` is high, per Avalon.
- DONE outputs:
  - Response is 10 if err=1, else 00.
  - readdata is the received data for reads and 0 for writes.
  - The register values are held until the next DONE.
- Byteenable is forwarded unchanged; an all-zero byteenable still produces a full frame.
- Reset values:
  - `waitrequest`=1.
  - `sclk`, `sle`, `sdo` = 0.
  - readdata = 0, response = 00.
  - State IDLE; all counters 0; synchroniser flops 0.
- Reset asserted mid-frame forces the above immediately. The remote sees `sle` drop and must discard the partial frame.

## Timing
- All outputs are registered.
- `sclk` toggles every CLK_DIV cycles, in SHIFT and RECV only. It starts low, and each bit period is 2·CLK_DIV cycles.
- Transmit:
  - LOAD drives bit FRAME_W-1 onto `sdo` and sets `sle`=1.
  - Each `sclk` falling edge presents the next bit.
  - The remote samples on the rising edge.
- Receive:
  - The bridge samples `sdi` in the cycle `sclk` is driven high.
  - `sclk` ends low when leaving RECV.
- Phase durations:
  - IDLE→LOAD: 1 cycle.
  - LOAD: 1 cycle.
  - SHIFT: exactly 2·CLK_DIV·FRAME_W cycles.
  - WAIT_RDY: ≥1 cycle, plus 2 cycles of synchroniser latency after `srdy` rises.
  - RECV: exactly 2·CLK_DIV·RESP_W cycles.
  - DONE: 1 cycle.
- The timeout counter counts WAIT_RDY cycles only and clears on entry.
- `srdy` already high on WAIT_RDY entry gives RECV in the next cycle.

## Structure
- Package `qsys_serial_pkg` holds:
  - the state enum;
  - response codes RESP_OKAY/RESP_SLVERR/RESP_DECERR;
  - FRAME_W/RESP_W functions of ADDR_W/DATA_W.
- Sub-module `qsys_serial_clkgen`: CLK_DIV counter with enable, producing `sclk` plus one-cycle rise/fall strobes.
- The top level holds the FSM, the FRAME_W shift register, the bit counter, the timeout counter and the `srdy` synchroniser.

## Test plan
All scenarios use default parameters: FRAME_W=45, read RESP_W=33.
- Write addr 0x12, data 0xA5A5_0F0F, be 0xF, with the remote raising `srdy` and returning err=0:
  - `sdo` captured on `sclk` rises = 45'h1_F12_A5A5_0F0F;
  - SHIFT lasts 180 cycles;
  - `waitrequest` low for 1 cycle with response 00.
- Read addr 0x34; the remote returns {0, 0xDEAD_BEEF}:
  - frame bits = {0, F, 34, 0};
  - DONE gives readdata 0xDEAD_BEEF, response 00.
- Read; the remote returns err=1:
  - response 10, readdata equal to the received data.
- `srdy` never rises:
  - DONE exactly 1023 WAIT_RDY cycles after entry;
  - response 11, readdata 0;
  - the next transaction succeeds.
- Write with be=0x5 and read high simultaneously:
  - a write frame is sent, byteenable field = 0x5.
- Assert `rsi_MRST_reset_n` low at SHIFT bit 20:
  - `sle`/`sclk`/`sdo` = 0 and `waitrequest`=1 in the same cycle;
  - after release, a fresh read completes normally.
